// File: rtl/ex_mem_pipe_if.sv
// EX/MEM stage bus: EX-side handshake and payload, MEM-side handshake and payload, flush and redirect.
// The slave modport is the pipeline stage; the master modport is the surrounding pipeline.
interface ex_mem_pipe_if #(
   parameter int WIDTH = 32,
   parameter int RA_W  = 5
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_y;
   logic             in_zf;
   logic             in_cf;
   logic             in_of;
   logic             in_sf;
   logic [WIDTH-1:0] in_b;
   logic [RA_W-1:0]  in_rd;
   logic             in_we;
   logic             in_mrd;
   logic             in_mwr;
   logic [1:0]       in_br;
   logic [WIDTH-1:0] in_tgt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   logic [WIDTH-1:0] out_b;
   logic [RA_W-1:0]  out_rd;
   logic             out_we;
   logic             out_mrd;
   logic             out_mwr;
   logic             redirect;
   logic [WIDTH-1:0] redirect_pc;

   modport slave (
      input  flush, in_valid, in_y, in_zf, in_cf, in_of, in_sf, in_b, in_rd,
             in_we, in_mrd, in_mwr, in_br, in_tgt, out_ready,
      output in_ready, out_valid, out_y, out_b, out_rd, out_we, out_mrd, out_mwr,
             redirect, redirect_pc
   );

   modport master (
      output flush, in_valid, in_y, in_zf, in_cf, in_of, in_sf, in_b, in_rd,
             in_we, in_mrd, in_mwr, in_br, in_tgt, out_ready,
      input  in_ready, out_valid, out_y, out_b, out_rd, out_we, out_mrd, out_mwr,
             redirect, redirect_pc
   );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with valid/ready handshake, branch resolution and registered redirect.
// Define EX_MEM_SKID_EN for a one-entry skid buffer with a registered in_ready.
module ex_mem_pipe #(
   parameter int WIDTH = 32,
   parameter int RA_W  = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   ex_mem_pipe_if.slave  pipe
);

   typedef struct packed {
      logic [WIDTH-1:0] y;
      logic [WIDTH-1:0] b;
      logic [RA_W-1:0]  rd;
      logic             we;
      logic             mrd;
      logic             mwr;
   } entry_t;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_EQ   = 2'b01;
   localparam logic [1:0] BR_NE   = 2'b10;
   localparam logic [1:0] BR_LT   = 2'b11;

   entry_t           in_entry;
   entry_t           main_q, main_d;
   logic             main_vld_q, main_vld_d;
   logic             redirect_q, redirect_d;
   logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
   logic             taken;
   logic             accept;
   logic             drain;

   assign in_entry = '{y: pipe.in_y, b: pipe.in_b, rd: pipe.in_rd,
                       we: pipe.in_we, mrd: pipe.in_mrd, mwr: pipe.in_mwr};

   // Carry flag plays no part in any supported condition.
   always_comb begin
      taken = 1'b0;
      case (pipe.in_br)
         BR_NONE: taken = 1'b0;
         BR_EQ:   taken = pipe.in_zf;
         BR_NE:   taken = ~pipe.in_zf;
         BR_LT:   taken = pipe.in_sf ^ pipe.in_of;
      endcase
   end

   assign accept = pipe.in_valid & pipe.in_ready & ~pipe.flush;
   assign drain  = main_vld_q & pipe.out_ready;

`ifdef EX_MEM_SKID_EN
   entry_t skid_q, skid_d;
   logic   skid_vld_q, skid_vld_d;

   assign pipe.in_ready = ~skid_vld_q;

   // NOTE: every always_comb output gets a hold default first, so no path can infer a latch.
   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (pipe.flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!main_vld_q || drain) begin
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else if (accept) begin
            main_d     = in_entry;
            main_vld_d = 1'b1;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (accept) begin
         skid_d     = in_entry;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
      end else begin
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
      end
   end
`else
   assign pipe.in_ready = ~main_vld_q | pipe.out_ready;

   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      if (pipe.flush) begin
         main_vld_d = 1'b0;
      end else if (accept) begin
         main_d     = in_entry;
         main_vld_d = 1'b1;
      end else if (drain) begin
         main_vld_d = 1'b0;
      end
   end
`endif

   assign redirect_d    = accept & taken;
   assign redirect_pc_d = redirect_d ? pipe.in_tgt : redirect_pc_q;

   // Payload is reset as well so every MEM-side output reads zero during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q        <= '0;
         main_vld_q    <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         main_q        <= main_d;
         main_vld_q    <= main_vld_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign pipe.out_valid   = main_vld_q;
   assign pipe.out_y       = main_q.y;
   assign pipe.out_b       = main_q.b;
   assign pipe.out_rd      = main_q.rd;
   assign pipe.out_we      = main_q.we;
   assign pipe.out_mrd     = main_q.mrd;
   assign pipe.out_mwr     = main_q.mwr;
   assign pipe.redirect    = redirect_q;
   assign pipe.redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: branch table, stall/flush/reset sequences, random traffic vs a queue model.
// Builds against either configuration of EX_MEM_SKID_EN.
module tb_ex_mem_pipe;

`ifdef EX_MEM_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif
   localparam int CAP = SKID ? 2 : 1;

   typedef struct packed {
      logic [31:0] y;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        we;
      logic        mrd;
      logic        mwr;
   } ent_t;

   typedef struct {
      logic [1:0]  br;
      logic        zf, cf, of, sf;
      logic [31:0] y;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] tgt;
      logic        exp_redir;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ex_mem_pipe_if #(.WIDTH(32), .RA_W(5)) bus ();
   ex_mem_pipe #(.WIDTH(32), .RA_W(5)) dut (.clk(clk), .rst_n(rst_n), .pipe(bus));

   int          n_checks = 0;
   int          n_err    = 0;
   ent_t        q[$];
   logic        exp_redirect;
   logic [31:0] exp_pc;
   logic        last_acc;
   logic [31:0] emitted[$];
   vec_t        vt[10];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic model_taken(logic [1:0] br, logic zf, logic sf, logic of);
      case (br)
         2'd1:    return zf;
         2'd2:    return !zf;
         2'd3:    return sf != of;
         default: return 1'b0;
      endcase
   endfunction

   task automatic present(ent_t e, logic [1:0] br, logic zf, logic cf, logic of, logic sf,
                          logic [31:0] tgt);
      bus.in_valid = 1'b1;
      bus.in_y = e.y; bus.in_b = e.b; bus.in_rd = e.rd;
      bus.in_we = e.we; bus.in_mrd = e.mrd; bus.in_mwr = e.mwr;
      bus.in_br = br; bus.in_zf = zf; bus.in_cf = cf; bus.in_of = of; bus.in_sf = sf;
      bus.in_tgt = tgt;
   endtask

   task automatic model_reset();
      q.delete();
      exp_redirect = 1'b0;
      exp_pc       = '0;
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_out_valid"}, bus.out_valid, 0);
      check({tag, "_out_y"}, bus.out_y, 0);
      check({tag, "_out_b"}, bus.out_b, 0);
      check({tag, "_out_rd"}, bus.out_rd, 0);
      check({tag, "_out_we"}, bus.out_we, 0);
      check({tag, "_out_mrd"}, bus.out_mrd, 0);
      check({tag, "_out_mwr"}, bus.out_mwr, 0);
      check({tag, "_redirect"}, bus.redirect, 0);
      check({tag, "_redirect_pc"}, bus.redirect_pc, 0);
   endtask

   // One clock: compare DUT against the queue model, then advance the model across the edge.
   task automatic step();
      logic exp_ready, acc, drn, tk;
      ent_t e;
      #2;
      exp_ready = (q.size() < CAP) || (!SKID && bus.out_ready);
      check("in_ready", bus.in_ready, exp_ready);
      check("out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
         check("out_y", bus.out_y, q[0].y);
         check("out_b", bus.out_b, q[0].b);
         check("out_ctl", {bus.out_rd, bus.out_we, bus.out_mrd, bus.out_mwr},
               {q[0].rd, q[0].we, q[0].mrd, q[0].mwr});
      end
      check("redirect", bus.redirect, exp_redirect);
      check("redirect_pc", bus.redirect_pc, exp_pc);
      if (bus.out_valid === 1'b1 && bus.out_ready) emitted.push_back(bus.out_y);

      acc = bus.in_valid && exp_ready && !bus.flush;
      drn = (q.size() != 0) && bus.out_ready;
      e   = '{y: bus.in_y, b: bus.in_b, rd: bus.in_rd, we: bus.in_we,
              mrd: bus.in_mrd, mwr: bus.in_mwr};
      tk  = model_taken(bus.in_br, bus.in_zf, bus.in_sf, bus.in_of);
      if (bus.flush) q.delete();
      else begin
         if (drn) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
      exp_redirect = acc && tk;
      if (exp_redirect) exp_pc = bus.in_tgt;
      last_acc = acc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
   endtask

   initial begin
      ent_t items[3];
      ent_t e;
      int   idx;

      rst_n = 1'b0;
      bus.flush = 0; bus.in_valid = 0; bus.out_ready = 0;
      bus.in_y = 0; bus.in_b = 0; bus.in_rd = 0; bus.in_we = 0; bus.in_mrd = 0; bus.in_mwr = 0;
      bus.in_br = 0; bus.in_zf = 0; bus.in_cf = 0; bus.in_of = 0; bus.in_sf = 0; bus.in_tgt = 0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      model_reset();
      #1;
      check("in_ready_after_reset", bus.in_ready, 1);

      //           br    zf cf of sf  y              rd  we  tgt           redir
      vt[0] = '{2'b00, 0, 0, 0, 0, 32'h0000_0005, 3,  1, 32'h0000_0000, 0};
      vt[1] = '{2'b01, 1, 0, 0, 0, 32'h0000_0000, 0,  0, 32'h0000_0040, 1};
      vt[2] = '{2'b01, 0, 0, 0, 0, 32'h0000_0011, 0,  0, 32'h0000_0080, 0};
      vt[3] = '{2'b11, 0, 0, 0, 1, 32'hFFFF_FFFE, 0,  0, 32'h0000_0100, 1};
      vt[4] = '{2'b11, 0, 0, 1, 1, 32'h7FFF_FFFF, 0,  0, 32'h0000_0200, 0};
      vt[5] = '{2'b10, 0, 0, 0, 0, 32'h0000_0003, 0,  0, 32'h0000_0300, 1};
      vt[6] = '{2'b10, 1, 0, 0, 0, 32'h0000_0000, 0,  0, 32'h0000_0400, 0};
      vt[7] = '{2'b00, 1, 1, 0, 0, 32'hDEAD_BEEF, 31, 1, 32'h0000_0500, 0};
      vt[8] = '{2'b11, 0, 0, 1, 0, 32'h8000_0000, 0,  0, 32'h0000_0600, 1};
      vt[9] = '{2'b01, 0, 1, 0, 0, 32'h0000_0001, 0,  0, 32'h0000_0700, 0};

      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         e = '{y: vt[i].y, b: 32'h1000 + i, rd: vt[i].rd, we: vt[i].we, mrd: 0, mwr: 0};
         present(e, vt[i].br, vt[i].zf, vt[i].cf, vt[i].of, vt[i].sf, vt[i].tgt);
         step();
         idle();
         #1;
         check($sformatf("vec%0d_out_valid", i), bus.out_valid, 1);
         check($sformatf("vec%0d_out_y", i), bus.out_y, vt[i].y);
         check($sformatf("vec%0d_out_rd_we", i), {bus.out_rd, bus.out_we}, {vt[i].rd, vt[i].we});
         check($sformatf("vec%0d_redirect", i), bus.redirect, vt[i].exp_redir);
         if (vt[i].exp_redir) check($sformatf("vec%0d_redirect_pc", i), bus.redirect_pc, vt[i].tgt);
         step();
         #1;
         check($sformatf("vec%0d_redirect_pulse_end", i), bus.redirect, 0);
      end

      // Back-pressure with A, B, C presented back to back.
      items[0] = '{y: 32'hA0A0_0001, b: 32'h1, rd: 1, we: 1, mrd: 0, mwr: 0};
      items[1] = '{y: 32'hB0B0_0002, b: 32'h2, rd: 2, we: 1, mrd: 1, mwr: 0};
      items[2] = '{y: 32'hC0C0_0003, b: 32'h3, rd: 3, we: 0, mrd: 0, mwr: 1};
      emitted.delete();
      idx = 0;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (c == 4) bus.out_ready = 1'b1;
         if (idx < 3) present(items[idx], 2'b00, 0, 0, 0, 0, 0);
         else idle();
         #1;
         if (c >= 1 && c < 4) check($sformatf("stall_hold_y_c%0d", c), bus.out_y, items[0].y);
         if (c == 1) check("stall_ready_c1", bus.in_ready, SKID);
         if (c == 2) check("stall_ready_c2", bus.in_ready, 0);
         step();
         if (last_acc) idx++;
      end
      check("stall_emit_count", emitted.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < emitted.size()) check($sformatf("stall_emit%0d", i), emitted[i], items[i].y);

      // Flush with the stage full and a taken branch arriving.
      bus.out_ready = 1'b0;
      e = '{y: 32'h1111_0001, b: 0, rd: 4, we: 1, mrd: 0, mwr: 0};
      present(e, 2'b00, 0, 0, 0, 0, 0);
      step();
      e.y = 32'h1111_0002;
      present(e, 2'b00, 0, 0, 0, 0, 0);
      step();
      e.y = 32'h1111_0003;
      present(e, 2'b01, 1, 0, 0, 0, 32'h0000_1234);
      bus.flush = 1'b1;
      step();
      idle();
      #1;
      check("flush_full_out_valid", bus.out_valid, 0);
      check("flush_full_redirect", bus.redirect, 0);
      step();
      // Flush with the stage empty so the taken branch would otherwise be accepted.
      bus.out_ready = 1'b1;
      present(e, 2'b01, 1, 0, 0, 0, 32'h0000_5678);
      bus.flush = 1'b1;
      step();
      idle();
      #1;
      check("flush_empty_out_valid", bus.out_valid, 0);
      check("flush_empty_redirect", bus.redirect, 0);
      step();
      e.y = 32'h2222_0001;
      present(e, 2'b00, 0, 0, 0, 0, 0);
      step();
      idle();
      #1;
      check("post_flush_out_valid", bus.out_valid, 1);
      check("post_flush_out_y", bus.out_y, 32'h2222_0001);
      step();

      // Asynchronous reset in the middle of a stall with both entries occupied.
      bus.out_ready = 1'b0;
      e = '{y: 32'h3333_0001, b: 32'h55, rd: 7, we: 1, mrd: 1, mwr: 1};
      present(e, 2'b00, 0, 0, 0, 0, 0);
      step();
      e.y = 32'h3333_0002;
      present(e, 2'b10, 0, 0, 0, 0, 32'h0000_0777);
      step();
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("in_ready_after_midreset", bus.in_ready, 1);
      bus.out_ready = 1'b1;
      repeat (3) step();

      // Random traffic against the queue model.
      for (int c = 0; c < 500; c++) begin
         e = '{y: $urandom, b: $urandom, rd: 5'($urandom_range(0, 31)),
               we: 1'($urandom_range(0, 1)), mrd: 1'($urandom_range(0, 1)),
               mwr: 1'($urandom_range(0, 1))};
         present(e, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.flush     = ($urandom_range(0, 15) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
